// File: rtl/lsu_dmem_if.sv
// Load/store unit to data-memory bus bridge for an RV32I core: size/sign decode,
// byte-lane steering, bus handshake with timeout, and load alignment/extension.
module lsu_dmem_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

  state_e        state_q, state_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;

  logic        f3_bad, misaligned;
  logic [3:0]  be_cmd;
  logic [31:0] wdata_cmd, rd_shift, ld_ext;

  // Unsigned variants exist only for loads; H/W must be naturally aligned.
  assign f3_bad     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && req_we);
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  always_comb begin
    be_cmd    = 4'b1111;
    wdata_cmd = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_cmd    = 4'b0001 << addr[1:0];
        wdata_cmd = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_cmd    = 4'b0011 << addr[1:0];
        wdata_cmd = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_shift = bus_rdata >> {lane_q, 3'b000};

  always_comb begin
    ld_ext = bus_rdata;
    case (f3_q[1:0])
      2'b00:   ld_ext = {{24{~f3_q[2] & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   ld_ext = {{16{~f3_q[2] & rd_shift[15]}}, rd_shift[15:0]};
      default: ;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    load_data_d = load_data_q;
    err_d       = 1'b0;
    timer_d     = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (f3_bad || misaligned) begin
            state_d     = ST_DONE;
            err_d       = 1'b1;
            load_data_d = '0;
          end else begin
            state_d     = ST_ACCESS;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = be_cmd;
            bus_wdata_d = wdata_cmd;
            f3_d        = funct3;
            lane_d      = addr[1:0];
            timer_d     = '0;
          end
        end
      end
      ST_ACCESS: begin
        // An ack arriving in the final allowed cycle still wins over the timeout.
        if (bus_ack) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) load_data_d = ld_ext;
        end else if (timer_q == T_LAST) begin
          state_d     = ST_DONE;
          bus_req_d   = 1'b0;
          err_d       = 1'b1;
          load_data_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      f3_q        <= '0;
      lane_q      <= '0;
      load_data_q <= '0;
      err_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
    end
  end

  assign stall     = req_valid && (state_q != ST_DONE);
  assign load_data = load_data_q;
  assign mem_err   = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: doc/lsu_dmem_if.md
LSU_DMEM_IF -- requirements
Module: lsu_dmem_if

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max bus wait cycles before error.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core memory instruction present; held until stall low.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address from ALU.
REQ-008 wdata  input  32  store data, rs2.
REQ-009 stall  output  1  freezes PC/regfile write while access pending.
REQ-010 load_data  output  32  aligned, extended load result, feeds writeback select mux data input.
REQ-011 mem_err  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout.
REQ-012 bus_req  output  1  bus request, held until bus_ack.
REQ-013 bus_we, bus_addr[31:0], bus_be[3:0], bus_wdata[31:0]  outputs  bus command.
REQ-014 bus_ack  input  1  bus completion, one cycle.
REQ-015 bus_rdata  input  32  read word, valid with bus_ack.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE.
REQ-017 IDLE, req_valid=1, legal and aligned: latch command, go ACCESS, assert bus_req next cycle.
REQ-018 IDLE, req_valid=1, illegal funct3 (011/110/111, or 100/101 with req_we=1) or misaligned (H with addr[0]=1, W with addr[1:0]!=0): no bus access, go DONE, pulse mem_err in DONE cycle, load_data=0.
REQ-019 ACCESS: hold bus_req and command stable until bus_ack; bus_ack -> capture result, deassert bus_req, go DONE.
REQ-020 ACCESS: timeout counter counts cycles from entry; reaching TIMEOUT_CYCLES without ack -> drop bus_req, go DONE, pulse mem_err, load_data=0; late ack then ignored.
REQ-021 DONE: stall=0 for exactly one cycle, then IDLE unconditionally.
REQ-022 stall = req_valid AND state!=DONE, combinational; req_valid=0 -> stall=0.
REQ-023 bus_addr = {addr[31:2],2'b00}.
REQ-024 bus_be: B -> 0001<<addr[1:0]; H -> 0011<<addr[1:0]; W -> 1111; loads drive same mask.
REQ-025 bus_wdata: B -> wdata[7:0] replicated x4; H -> wdata[15:0] replicated x2; W -> wdata.
REQ-026 Loads: select byte/half by addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend.
REQ-027 load_data registered, stable from DONE until next bus_ack or error; stores leave it unchanged.
REQ-028 Back-to-back memory instructions: IDLE re-entered one cycle after DONE; minimum 3 cycles per access with immediate ack.
REQ-029 req_valid dropping in ACCESS (flush): bus transaction still completes; no mem_err.

Reset
REQ-030 rst_n low: state IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, load_data=0, mem_err=0, timeout counter 0, effective immediately, independent of clk.
REQ-031 Reset mid-ACCESS abandons transaction; first cycle after release is IDLE.

Verification
REQ-032 LB addr=0x103, bus_rdata=0x80112233 ack next cycle -> bus_addr=0x100, bus_be=1000, load_data=0xFFFFFF80, stall low one cycle.
REQ-033 LHU addr=0x202, bus_rdata=0xBEEF1234 -> bus_be=1100, load_data=0x0000BEEF.
REQ-034 SB addr=0x11, wdata=0x000000A5 -> bus_we=1, bus_be=0010, bus_wdata=0xA5A5A5A5, load_data unchanged.
REQ-035 LW addr=0x102 -> no bus_req, mem_err one pulse, load_data=0, stall low in DONE.
REQ-036 LW, bus_ack never, TIMEOUT_CYCLES=4 -> bus_req high 4 cycles, then mem_err pulse, FSM reaches IDLE.
REQ-037 rst_n low during ACCESS -> bus_req=0 same cycle asynchronously; after release, new SW completes normally.
